// File: rtl/instr_mem_loader_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_if
//   Groups the byte-stream handshake and the instruction-memory write port of
//   the loader.
//   slave  : the loader side (consumes the stream, drives the write port)
//   master : the environment side (produces the stream, observes the writes)
//
//   in_valid  : stream byte present
//   in_data   : stream byte
//   in_ready  : loader accepts a byte this cycle
//   mem_we    : one-cycle write strobe per assembled word
//   mem_addr  : word index for the write
//   mem_wdata : assembled 32-bit instruction word
// -----------------------------------------------------------------------------
interface instr_mem_loader_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Fills instruction memory from a byte stream. The stream is a 16-bit
//   big-endian word count N followed by 4*N bytes; each group of four bytes
//   forms one big-endian instruction word written to consecutive word
//   addresses starting at BASE_ADDR.
//
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : pulse, begins a load from IDLE, DONE or ERR
//   abort         : pulse, cancels a load in progress
//   bus           : stream handshake + memory write port (slave modport)
//   busy          : header or data phase in progress
//   done          : last load completed, held until next start
//   error         : last header rejected (too long), held until next start
//   words_written : words written by the current or last load
// -----------------------------------------------------------------------------
module instr_mem_loader #(
   parameter int DEPTH     = 2048,
   parameter int BASE_ADDR = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   instr_mem_loader_if.slave         bus,
   input  logic                      start,
   input  logic                      abort,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [15:0]               words_written
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_DONE,
      S_ERR
   } state_e;

   state_e      state;
   state_e      state_nxt;
   logic [15:0] length;
   logic [1:0]  byte_cnt;
   logic [23:0] word_sr;

   logic        accept;
   logic        take;
   logic [15:0] len_new;
   logic [32:0] len_end;
   logic        len_bad;
   logic        last_word;

   // in_ready is a register, so a transfer never depends combinationally on
   // itself. An abort in the same cycle suppresses the byte: nothing of it is
   // kept.
   assign accept    = bus.in_valid && bus.in_ready;
   assign take      = accept && !abort;

   // Length as it will be once the low header byte lands.
   assign len_new   = {length[15:8], bus.in_data};
   assign len_end   = 33'(BASE_ADDR) + {17'd0, len_new};
   assign len_bad   = len_end > 33'(DEPTH);

   assign last_word = ({1'b0, words_written} + 17'd1) == {1'b0, length};

   // NOTE: every output of an always_comb gets a default first, otherwise a
   // path that skips the assignment infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (abort)       state_nxt = S_IDLE;
            else if (accept) state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (accept) begin
               if (len_new == 16'd0) state_nxt = S_DONE;
               else if (len_bad)     state_nxt = S_ERR;
               else                  state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (abort)                                     state_nxt = S_IDLE;
            else if (accept && byte_cnt == 2'd3 && last_word) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status flags are registered from the next state so they change on the
   // same edge as the state itself and never follow the inputs directly.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   // NOTE: all datapath registers are reset as well; they are small and a
   // known value avoids X on mem_addr/mem_wdata after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         bus.in_ready  <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         words_written <= '0;
         length        <= '0;
         byte_cnt      <= '0;
         word_sr       <= '0;
      end else begin
         state        <= state_nxt;
         bus.in_ready <= state_nxt inside {S_LEN_HI, S_LEN_LO, S_DATA};
         busy         <= state_nxt inside {S_LEN_HI, S_LEN_LO, S_DATA};
         done         <= state_nxt == S_DONE;
         error        <= state_nxt == S_ERR;
         bus.mem_we   <= 1'b0;

         if (start && (state inside {S_IDLE, S_DONE, S_ERR})) begin
            words_written <= '0;
         end

         if (state == S_LEN_HI && take) begin
            length[15:8] <= bus.in_data;
         end

         if (state == S_LEN_LO && take) begin
            length[7:0] <= bus.in_data;
            byte_cnt    <= '0;
         end

         if (state == S_DATA && take) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_sr  <= {word_sr[15:0], bus.in_data};
            if (byte_cnt == 2'd3) begin
               bus.mem_we    <= 1'b1;
               bus.mem_wdata <= {word_sr, bus.in_data};
               bus.mem_addr  <= 32'(BASE_ADDR) + 32'(words_written);
               words_written <= words_written + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
//   Table-driven loads (length / throttle / expected outcome) plus hand-written
//   sequences for the exact-byte load, abort, start-while-busy and async reset.
//   Expected writes go into a scoreboard queue as the stream is driven and are
//   popped by a monitor whenever mem_we is seen.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

   localparam int DEPTH = 2048;
   localparam int BASE  = 0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_written;

   instr_mem_loader_if bus ();

   instr_mem_loader #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .start         (start),
      .abort         (abort),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      string       name;
      logic [15:0] n;
      bit          thr;
      bit          exp_done;
      bit          exp_err;
      logic [15:0] exp_words;
   } vec_t;

   wr_t         sb[$];
   int          total = 0;
   int          bad = 0;
   int          writes_seen = 0;
   logic [31:0] last_addr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Write monitor: every mem_we pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && bus.mem_we === 1'b1) begin
         writes_seen++;
         last_addr = bus.mem_addr;
         if (sb.size() == 0) begin
            check("write_expected", 32'(sb.size() != 0), 32'd1);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", bus.mem_addr, e.addr);
            check("wr_data", bus.mem_wdata, e.data);
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Present one byte and hold it until it is accepted; returns 1 time unit
   // after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input bit thr);
      int guard;
      @(negedge clk);
      if (thr) repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 bus.in_valid = 1'b0;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input bit thr);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], thr);
   endtask

   task automatic wait_end();
      int guard;
      guard = 0;
      @(negedge clk);
      while (!(done || error) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) check("end_timeout", 32'(done || error), 32'd1);
   endtask

   vec_t vecs[6];

   initial begin
      int          w0;
      logic [31:0] d;

      vecs[0] = '{"zero_len",   16'h0000, 1'b0, 1'b1, 1'b0, 16'd0};
      vecs[1] = '{"oversize",   16'h0801, 1'b0, 1'b0, 1'b1, 16'd0};
      vecs[2] = '{"thr_n3",     16'h0003, 1'b1, 1'b1, 1'b0, 16'd3};
      vecs[3] = '{"b2b_n5",     16'h0005, 1'b0, 1'b1, 1'b0, 16'd5};
      vecs[4] = '{"max_len",    16'h0800, 1'b0, 1'b1, 1'b0, 16'd2048};
      vecs[5] = '{"len_ffff",   16'hFFFF, 1'b1, 1'b0, 1'b1, 16'd0};

      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // Reset state
      #22;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_mem_we",   32'(bus.mem_we),   32'd0);
      check("rst_mem_addr", bus.mem_addr,      32'd0);
      check("rst_busy",     32'(busy),         32'd0);
      check("rst_done",     32'(done),         32'd0);
      check("rst_error",    32'(error),        32'd0);
      check("rst_words",    32'(words_written), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_in_ready", 32'(bus.in_ready), 32'd0);

      // Basic load with fixed bytes; done must coincide with the last write.
      w0 = writes_seen;
      sb.push_back('{32'd0, 32'h2008_0005});
      sb.push_back('{32'd1, 32'h2009_0007});
      pulse_start();
      check("busy_after_start", 32'(busy), 32'd1);
      send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
      send_byte(8'h20, 1'b0); send_byte(8'h08, 1'b0);
      send_byte(8'h00, 1'b0); send_byte(8'h05, 1'b0);
      send_byte(8'h20, 1'b0); send_byte(8'h09, 1'b0);
      send_byte(8'h00, 1'b0); send_byte(8'h07, 1'b0);
      check("basic_last_we",   32'(bus.mem_we), 32'd1);
      check("basic_done_with_we", 32'(done),    32'd1);
      @(negedge clk);
      @(negedge clk);
      check("basic_writes",  32'(writes_seen - w0), 32'd2);
      check("basic_words",   32'(words_written),    32'd2);
      check("basic_in_ready", 32'(bus.in_ready),    32'd0);
      check("basic_sb_empty", 32'(sb.size()),       32'd0);

      // Same bytes, throttled.
      w0 = writes_seen;
      sb.push_back('{32'd0, 32'h2008_0005});
      sb.push_back('{32'd1, 32'h2009_0007});
      pulse_start();
      send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
      send_word(32'h2008_0005, 1'b1);
      send_word(32'h2009_0007, 1'b1);
      wait_end();
      @(negedge clk);
      check("thr_writes", 32'(writes_seen - w0), 32'd2);
      check("thr_done",   32'(done),             32'd1);
      check("thr_words",  32'(words_written),    32'd2);

      // Table-driven loads.
      for (int v = 0; v < 6; v++) begin
         w0 = writes_seen;
         pulse_start();
         send_byte(vecs[v].n[15:8], vecs[v].thr);
         send_byte(vecs[v].n[7:0],  vecs[v].thr);
         if (!vecs[v].exp_err) begin
            for (int w = 0; w < int'(vecs[v].n); w++) begin
               d = $urandom;
               sb.push_back('{32'(BASE + w), d});
               send_word(d, vecs[v].thr);
            end
         end
         wait_end();
         @(negedge clk);
         check({vecs[v].name, "_done"},     32'(done),             32'(vecs[v].exp_done));
         check({vecs[v].name, "_error"},    32'(error),            32'(vecs[v].exp_err));
         check({vecs[v].name, "_words"},    32'(words_written),    32'(vecs[v].exp_words));
         check({vecs[v].name, "_writes"},   32'(writes_seen - w0), 32'(vecs[v].exp_words));
         check({vecs[v].name, "_in_ready"}, 32'(bus.in_ready),     32'd0);
         check({vecs[v].name, "_busy"},     32'(busy),             32'd0);
         check({vecs[v].name, "_sb_empty"}, 32'(sb.size()),        32'd0);
         if (vecs[v].exp_done && vecs[v].n != 16'd0)
            check({vecs[v].name, "_last_addr"}, last_addr, 32'(BASE) + 32'(vecs[v].n) - 32'd1);
      end

      // Abort mid-word, with an ignored start while busy.
      w0 = writes_seen;
      sb.push_back('{32'd0, 32'h1111_2222});
      pulse_start();
      send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
      send_word(32'h1111_2222, 1'b0);
      send_byte(8'h33, 1'b0);
      pulse_start();
      check("start_busy_ignored", 32'(busy), 32'd1);
      send_byte(8'h44, 1'b0);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_busy",     32'(busy),             32'd0);
      check("abort_in_ready", 32'(bus.in_ready),     32'd0);
      check("abort_done",     32'(done),             32'd0);
      check("abort_error",    32'(error),            32'd0);
      check("abort_words",    32'(words_written),    32'd1);
      check("abort_writes",   32'(writes_seen - w0), 32'd1);

      // Reload after abort starts again at the base address.
      w0 = writes_seen;
      sb.push_back('{32'(BASE), 32'hCAFE_F00D});
      pulse_start();
      send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
      send_word(32'hCAFE_F00D, 1'b0);
      wait_end();
      @(negedge clk);
      check("reload_writes", 32'(writes_seen - w0), 32'd1);
      check("reload_done",   32'(done),             32'd1);

      // Async reset mid-load.
      sb.push_back('{32'd0, 32'hDEAD_BEEF});
      pulse_start();
      send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      send_byte(8'h55, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_in_ready",  32'(bus.in_ready),  32'd0);
      check("arst_mem_we",    32'(bus.mem_we),    32'd0);
      check("arst_mem_addr",  bus.mem_addr,       32'd0);
      check("arst_mem_wdata", bus.mem_wdata,      32'd0);
      check("arst_busy",      32'(busy),          32'd0);
      check("arst_done",      32'(done),          32'd0);
      check("arst_error",     32'(error),         32'd0);
      check("arst_words",     32'(words_written), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("post_rst_busy",     32'(busy),         32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
